// File: rtl/cam_pkg.sv
// Shared constants for the camera capture stage.
// Holds the default camera bus geometry, the width of the per-window
// decimation field and the stereo display/calc window coordinates that the
// integrating level programs into the capture windows.
package cam_pkg;

    // Default camera bus and counter geometry.
    localparam int unsigned CAM_DATA_W  = 3;
    localparam int unsigned CAM_X_W     = 10;
    localparam int unsigned CAM_Y_W     = 9;
    localparam int unsigned CAM_PHASES  = 2;
    localparam int unsigned CAM_NUM_WIN = 2;
    localparam int unsigned CAM_ADDR_W  = 16;
    localparam int unsigned CAM_DEPTH   = 10000;

    // Packed-slice helpers: window k of a packed config bus lives at k*<W> +: <W>.
    localparam int unsigned DECIM_W  = 2;
    localparam int unsigned WIN_DISP = 0;
    localparam int unsigned WIN_CALC = 1;

    // Stereo display window (inclusive bounds).
    localparam int unsigned DISP_X0 = 270;
    localparam int unsigned DISP_X1 = 369;
    localparam int unsigned DISP_Y0 = 190;
    localparam int unsigned DISP_Y1 = 289;

    // Distance-calculation window (inclusive bounds).
    localparam int unsigned CALC_X0 = 318;
    localparam int unsigned CALC_X1 = 396;
    localparam int unsigned CALC_Y0 = 238;
    localparam int unsigned CALC_Y1 = 253;

endpackage

// File: rtl/cam_window_capture_if.sv
// Bus bundle between the camera source / window configuration and the
// capture stage, plus the per-window RAM write ports.
//   master : drives vsync/href/d and win_* config, receives write ports/flags
//   slave  : the capture stage
interface cam_window_capture_if
    import cam_pkg::*;
#(
    parameter int unsigned DATA_W  = CAM_DATA_W,
    parameter int unsigned X_W     = CAM_X_W,
    parameter int unsigned Y_W     = CAM_Y_W,
    parameter int unsigned NUM_WIN = CAM_NUM_WIN,
    parameter int unsigned ADDR_W  = CAM_ADDR_W
) ();

    // Camera pixel bus
    logic                        vsync;
    logic                        href;
    logic [DATA_W-1:0]           d;

    // Window configuration, window k in slice k
    logic [NUM_WIN-1:0]          win_en;
    logic [NUM_WIN*X_W-1:0]      win_x0;
    logic [NUM_WIN*X_W-1:0]      win_x1;
    logic [NUM_WIN*Y_W-1:0]      win_y0;
    logic [NUM_WIN*Y_W-1:0]      win_y1;
    logic [NUM_WIN*DECIM_W-1:0]  win_decim;

    // Per-window RAM write ports and status
    logic [NUM_WIN*DATA_W-1:0]   wr_data;
    logic [NUM_WIN*ADDR_W-1:0]   wr_addr;
    logic [NUM_WIN-1:0]          wr_en;
    logic [NUM_WIN-1:0]          frame_done;
    logic [NUM_WIN-1:0]          overflow;

    modport master (
        output vsync, href, d, win_en, win_x0, win_x1, win_y0, win_y1, win_decim,
        input  wr_data, wr_addr, wr_en, frame_done, overflow
    );

    modport slave (
        input  vsync, href, d, win_en, win_x0, win_x1, win_y0, win_y1, win_decim,
        output wr_data, wr_addr, wr_en, frame_done, overflow
    );

endinterface

// File: rtl/cam_window_ctx.sv
// One capture window: shadowed configuration, hit compare with decimation,
// bounded write-address counter, sticky overflow and frame-done pulse.
// Ports:
//   pclk, resetn        clock, async active-low reset
//   vsync_i/_rise_i     frame blanking level and its rising edge
//   href_fall_i         end of the current line
//   pix_strobe_i        a pixel completes this cycle
//   x_i, y_i, d_i       coordinates and data of that pixel
//   en_i .. decim_i     live window config (sampled only during vsync)
//   wr_*_o, frame_done_o, overflow_o  registered write port and flags
module cam_window_ctx
    import cam_pkg::*;
#(
    parameter int unsigned DATA_W = CAM_DATA_W,
    parameter int unsigned X_W    = CAM_X_W,
    parameter int unsigned Y_W    = CAM_Y_W,
    parameter int unsigned ADDR_W = CAM_ADDR_W,
    parameter int unsigned DEPTH  = CAM_DEPTH
) (
    input  logic               pclk,
    input  logic               resetn,
    input  logic               vsync_i,
    input  logic               vsync_rise_i,
    input  logic               href_fall_i,
    input  logic               pix_strobe_i,
    input  logic [X_W-1:0]     x_i,
    input  logic [Y_W-1:0]     y_i,
    input  logic [DATA_W-1:0]  d_i,
    input  logic               en_i,
    input  logic [X_W-1:0]     x0_i,
    input  logic [X_W-1:0]     x1_i,
    input  logic [Y_W-1:0]     y0_i,
    input  logic [Y_W-1:0]     y1_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic [ADDR_W-1:0]  wr_addr_o,
    output logic               wr_en_o,
    output logic               frame_done_o,
    output logic               overflow_o
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic               en_q;
    logic [X_W-1:0]     x0_q, x1_q;
    logic [Y_W-1:0]     y0_q, y1_q;
    logic [DECIM_W-1:0] decim_q;

    logic [ADDR_W:0]    next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               wr_en_q, wr_en_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic [2:0]         dmask;
    logic [2:0]         dx_lo, dy_lo;
    logic               in_box, on_grid, hit, bounds_ok;

    // Shadow config: tracks the inputs while blanking, frozen during video.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            en_q    <= 1'b0;
            x0_q    <= '0;
            x1_q    <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            decim_q <= '0;
        end else if (vsync_i) begin
            en_q    <= en_i;
            x0_q    <= x0_i;
            x1_q    <= x1_i;
            y0_q    <= y0_i;
            y1_q    <= y1_i;
            decim_q <= decim_i;
        end
    end

    always_comb begin
        dmask = 3'b000;
        unique case (decim_q)
            2'd0: dmask = 3'b000;
            2'd1: dmask = 3'b001;
            2'd2: dmask = 3'b011;
            2'd3: dmask = 3'b111;
        endcase
    end

    // Offset residues only need the low bits of the difference.
    assign dx_lo     = x_i[2:0] - x0_q[2:0];
    assign dy_lo     = y_i[2:0] - y0_q[2:0];
    assign in_box    = (x_i >= x0_q) && (x_i <= x1_q) && (y_i >= y0_q) && (y_i <= y1_q);
    assign on_grid   = ((dx_lo & dmask) == 3'b000) && ((dy_lo & dmask) == 3'b000);
    assign hit       = en_q && !vsync_i && pix_strobe_i && in_box && on_grid;
    assign bounds_ok = (x0_q <= x1_q) && (y0_q <= y1_q);

    always_comb begin
        next_addr_d = next_addr_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        ovf_d       = ovf_q;

        if (vsync_i) begin
            next_addr_d = '0;
        end else if (hit) begin
            if (next_addr_q < DEPTH_C) begin
                wr_en_d     = 1'b1;
                wr_addr_d   = next_addr_q[ADDR_W-1:0];
                wr_data_d   = d_i;
                next_addr_d = next_addr_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (vsync_rise_i) begin
            ovf_d = 1'b0;
        end

        // A saturated y never advances past y1, so it cannot complete the window.
        done_d = en_q && bounds_ok && !vsync_i && href_fall_i && (y_i == y1_q) && (y1_q != '1);
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            next_addr_q <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            next_addr_q <= next_addr_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_data_o    = wr_data_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_en_o      = wr_en_q;
    assign frame_done_o = done_q;
    assign overflow_o   = ovf_q;

endmodule

// File: rtl/cam_window_capture.sv
// Camera-to-buffer capture stage with NUM_WIN independent rectangular windows.
// Tracks the byte phase within a pixel and the x/y position of the pixel being
// assembled, then fans the pixel out to one cam_window_ctx per window.
// Ports:
//   pclk    camera pixel clock (sole clock)
//   resetn  asynchronous active-low reset
//   cam_io  camera bus, window config, per-window write ports and flags
module cam_window_capture
    import cam_pkg::*;
#(
    parameter int unsigned DATA_W  = CAM_DATA_W,
    parameter int unsigned X_W     = CAM_X_W,
    parameter int unsigned Y_W     = CAM_Y_W,
    parameter int unsigned NUM_WIN = CAM_NUM_WIN,
    parameter int unsigned ADDR_W  = CAM_ADDR_W,
    parameter int unsigned DEPTH   = CAM_DEPTH,
    parameter int unsigned PHASES  = CAM_PHASES
) (
    input  logic                 pclk,
    input  logic                 resetn,
    cam_window_capture_if.slave  cam_io
);

    localparam int unsigned      PH_W    = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(PHASES - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic [X_W-1:0]  x_q, x_d;
    logic [Y_W-1:0]  y_q, y_d;
    logic            href_q;
    logic            vsync_q;
    logic            pix_strobe, href_fall, vsync_rise;

    assign pix_strobe = cam_io.href && (phase_q == PH_LAST);
    assign href_fall  = href_q && !cam_io.href;
    assign vsync_rise = cam_io.vsync && !vsync_q;

    always_comb begin
        phase_d = phase_q + 1'b1;
        if (!cam_io.href || pix_strobe) begin
            phase_d = '0;
        end

        x_d = x_q;
        y_d = y_q;
        if (cam_io.vsync) begin
            x_d = '0;
            y_d = '0;
        end else if (href_fall) begin
            x_d = '0;
            if (y_q != '1) begin
                y_d = y_q + 1'b1;
            end
        end else if (pix_strobe) begin
            // x wraps silently on over-long lines.
            x_d = x_q + 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            href_q  <= cam_io.href;
            vsync_q <= cam_io.vsync;
        end
    end

    for (genvar k = 0; k < NUM_WIN; k++) begin : g_win
        cam_window_ctx #(
            .DATA_W (DATA_W),
            .X_W    (X_W),
            .Y_W    (Y_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_ctx (
            .pclk         (pclk),
            .resetn       (resetn),
            .vsync_i      (cam_io.vsync),
            .vsync_rise_i (vsync_rise),
            .href_fall_i  (href_fall),
            .pix_strobe_i (pix_strobe),
            .x_i          (x_q),
            .y_i          (y_q),
            .d_i          (cam_io.d),
            .en_i         (cam_io.win_en[k]),
            .x0_i         (cam_io.win_x0[k*X_W +: X_W]),
            .x1_i         (cam_io.win_x1[k*X_W +: X_W]),
            .y0_i         (cam_io.win_y0[k*Y_W +: Y_W]),
            .y1_i         (cam_io.win_y1[k*Y_W +: Y_W]),
            .decim_i      (cam_io.win_decim[k*DECIM_W +: DECIM_W]),
            .wr_data_o    (cam_io.wr_data[k*DATA_W +: DATA_W]),
            .wr_addr_o    (cam_io.wr_addr[k*ADDR_W +: ADDR_W]),
            .wr_en_o      (cam_io.wr_en[k]),
            .frame_done_o (cam_io.frame_done[k]),
            .overflow_o   (cam_io.overflow[k])
        );
    end

endmodule

// File: tb/tb_cam_window_capture.sv
// Randomised scoreboard bench for cam_window_capture on a small 40x24 frame.
module tb_cam_window_capture;
    import cam_pkg::*;

    localparam int unsigned DATA_W  = CAM_DATA_W;
    localparam int unsigned X_W     = CAM_X_W;
    localparam int unsigned Y_W     = CAM_Y_W;
    localparam int unsigned NUM_WIN = 2;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DEPTH   = 100;
    localparam int unsigned PHASES  = 2;
    localparam int COLS   = 40;
    localparam int LINES  = 24;
    localparam int VS_CYC = 6;
    localparam int BL_CYC = 4;

    typedef struct { bit en; int x0; int x1; int y0; int y1; int decim; } cfg_t;
    typedef struct { int addr; int data; } wr_t;

    logic pclk   = 1'b0;
    logic resetn = 1'b1;
    int   cyc    = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    cam_window_capture_if #(
        .DATA_W (DATA_W), .X_W (X_W), .Y_W (Y_W), .NUM_WIN (NUM_WIN), .ADDR_W (ADDR_W)
    ) cam_if ();

    cam_window_capture #(
        .DATA_W (DATA_W), .X_W (X_W), .Y_W (Y_W), .NUM_WIN (NUM_WIN),
        .ADDR_W (ADDR_W), .DEPTH (DEPTH), .PHASES (PHASES)
    ) dut (
        .pclk   (pclk),
        .resetn (resetn),
        .cam_io (cam_if.slave)
    );

    cfg_t cfg [NUM_WIN];
    wr_t  exp_q [NUM_WIN][$];
    int   fd_q [NUM_WIN][$];
    int   cnt [NUM_WIN];
    bit   exp_ovf [NUM_WIN];
    int   n_checks = 0;
    int   n_fails  = 0;

    task automatic check(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s win %0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    // Reference: a pixel belongs to a window if it lies in the inclusive box
    // and on the 2**decim grid anchored at the window origin.
    function automatic bit model_hit(input cfg_t c, input int x, input int y);
        int step;
        step = 1 << c.decim;
        return c.en && x >= c.x0 && x <= c.x1 && y >= c.y0 && y <= c.y1 &&
               ((x - c.x0) % step) == 0 && ((y - c.y0) % step) == 0;
    endfunction

    task automatic model_pixel(input int x, input int y, input int dv);
        wr_t e;
        for (int k = 0; k < NUM_WIN; k++) begin
            if (model_hit(cfg[k], x, y)) begin
                if (cnt[k] < int'(DEPTH)) begin
                    e.addr = cnt[k];
                    e.data = dv;
                    exp_q[k].push_back(e);
                    cnt[k]++;
                end else begin
                    exp_ovf[k] = 1'b1;
                end
            end
        end
    endtask

    // Called on the first blank cycle of line ly; the pulse lands one cycle later.
    task automatic model_line_end(input int ly);
        for (int k = 0; k < NUM_WIN; k++) begin
            if (cfg[k].en && cfg[k].x0 <= cfg[k].x1 && cfg[k].y0 <= cfg[k].y1 &&
                ly == cfg[k].y1) begin
                fd_q[k].push_back(cyc + 1);
            end
        end
    endtask

    task automatic drive_cfg();
        for (int k = 0; k < NUM_WIN; k++) begin
            cam_if.win_en[k]                          = cfg[k].en;
            cam_if.win_x0[k*X_W +: X_W]               = X_W'(cfg[k].x0);
            cam_if.win_x1[k*X_W +: X_W]               = X_W'(cfg[k].x1);
            cam_if.win_y0[k*Y_W +: Y_W]               = Y_W'(cfg[k].y0);
            cam_if.win_y1[k*Y_W +: Y_W]               = Y_W'(cfg[k].y1);
            cam_if.win_decim[k*DECIM_W +: DECIM_W]    = DECIM_W'(cfg[k].decim);
        end
    endtask

    task automatic scribble_cfg();
        cam_if.win_en    = NUM_WIN'($urandom);
        cam_if.win_x0    = (NUM_WIN*X_W)'($urandom);
        cam_if.win_x1    = (NUM_WIN*X_W)'($urandom);
        cam_if.win_y0    = (NUM_WIN*Y_W)'($urandom);
        cam_if.win_y1    = (NUM_WIN*Y_W)'($urandom);
        cam_if.win_decim = (NUM_WIN*DECIM_W)'($urandom);
    endtask

    task automatic random_cfg();
        for (int k = 0; k < NUM_WIN; k++) begin
            cfg[k].en    = ($urandom_range(0, 3) != 0);
            cfg[k].x0    = int'($urandom_range(0, 35));
            cfg[k].x1    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, cfg[k].x0)) :
                           cfg[k].x0 + int'($urandom_range(0, 12));
            cfg[k].y0    = int'($urandom_range(0, 22));
            cfg[k].y1    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, cfg[k].y0)) :
                           cfg[k].y0 + int'($urandom_range(0, 8));
            cfg[k].decim = int'($urandom_range(0, 3));
        end
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        cam_if.href = 1'b0;
        #1;
        check("rst_wr_en",      -1, int'(cam_if.wr_en),      0);
        check("rst_wr_addr",    -1, int'(cam_if.wr_addr),    0);
        check("rst_wr_data",    -1, int'(cam_if.wr_data),    0);
        check("rst_frame_done", -1, int'(cam_if.frame_done), 0);
        check("rst_overflow",   -1, int'(cam_if.overflow),   0);
        for (int k = 0; k < NUM_WIN; k++) begin
            exp_q[k].delete();
            fd_q[k].delete();
            cnt[k]     = 0;
            exp_ovf[k] = 1'b0;
        end
        repeat (3) @(posedge pclk);
        #1 resetn = 1'b1;
    endtask

    // One frame: blanking with the frame's config, then LINES lines of COLS pixels.
    // abort_line >= 0 pulses resetn in the middle of that line.
    task automatic run_frame(input int abort_line);
        for (int k = 0; k < NUM_WIN; k++) begin
            cnt[k]     = 0;
            exp_ovf[k] = 1'b0;
        end
        for (int c = 0; c < VS_CYC; c++) begin
            @(posedge pclk); #1;
            cam_if.vsync = 1'b1;
            cam_if.href  = 1'b0;
            cam_if.d     = DATA_W'($urandom);
            if (c == 0) drive_cfg();
            if (c == VS_CYC - 1) begin
                for (int k = 0; k < NUM_WIN; k++)
                    check("overflow_clear", k, int'(cam_if.overflow[k]), 0);
            end
        end
        for (int ly = 0; ly < LINES; ly++) begin
            for (int cx = 0; cx < COLS; cx++) begin
                for (int ph = 0; ph < int'(PHASES); ph++) begin
                    @(posedge pclk); #1;
                    if (ly == abort_line && cx == COLS / 2 && ph == 0) begin
                        do_reset();
                        return;
                    end
                    cam_if.vsync = 1'b0;
                    cam_if.href  = 1'b1;
                    cam_if.d     = DATA_W'($urandom);
                    // Live config changes during video must not reach this frame.
                    if (cx == 0 && ph == 0) scribble_cfg();
                    if (ph == int'(PHASES) - 1) model_pixel(cx, ly, int'(cam_if.d));
                end
            end
            for (int b = 0; b < BL_CYC; b++) begin
                @(posedge pclk); #1;
                cam_if.href = 1'b0;
                if (b == 0) model_line_end(ly);
            end
        end
        for (int k = 0; k < NUM_WIN; k++) begin
            check("writes_outstanding",     k, exp_q[k].size(), 0);
            check("frame_done_outstanding", k, fd_q[k].size(), 0);
            check("overflow",               k, int'(cam_if.overflow[k]), int'(exp_ovf[k]));
        end
    endtask

    task automatic run_monitor();
        wr_t e;
        int  due;
        forever begin
            @(negedge pclk);
            if (resetn) begin
                for (int k = 0; k < NUM_WIN; k++) begin
                    if (cam_if.wr_en[k]) begin
                        check("wr_en_expected", k, int'(cam_if.wr_en[k]),
                              int'(exp_q[k].size() != 0));
                        if (exp_q[k].size() != 0) begin
                            e = exp_q[k].pop_front();
                            check("wr_addr", k, int'(cam_if.wr_addr[k*ADDR_W +: ADDR_W]), e.addr);
                            check("wr_data", k, int'(cam_if.wr_data[k*DATA_W +: DATA_W]), e.data);
                        end
                    end
                    if (cam_if.frame_done[k]) begin
                        check("frame_done_expected", k, int'(cam_if.frame_done[k]),
                              int'(fd_q[k].size() != 0));
                        if (fd_q[k].size() != 0) begin
                            due = fd_q[k].pop_front();
                            check("frame_done_cycle", k, cyc, due);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        cam_if.vsync     = 1'b0;
        cam_if.href      = 1'b0;
        cam_if.d         = '0;
        cam_if.win_en    = '0;
        cam_if.win_x0    = '0;
        cam_if.win_x1    = '0;
        cam_if.win_y0    = '0;
        cam_if.win_y1    = '0;
        cam_if.win_decim = '0;
        for (int k = 0; k < NUM_WIN; k++) begin
            cnt[k]     = 0;
            exp_ovf[k] = 1'b0;
        end
        fork
            run_monitor();
        join_none

        #2 resetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("reset_wr_en",      -1, int'(cam_if.wr_en),      0);
        check("reset_wr_addr",    -1, int'(cam_if.wr_addr),    0);
        check("reset_wr_data",    -1, int'(cam_if.wr_data),    0);
        check("reset_frame_done", -1, int'(cam_if.frame_done), 0);
        check("reset_overflow",   -1, int'(cam_if.overflow),   0);
        resetn = 1'b1;

        // 20x20 window into a 100-deep RAM, plus a decimated 8x4 window.
        cfg[0] = '{1'b1, 2, 21, 1, 20, 0};
        cfg[1] = '{1'b1, 0, 7, 0, 3, 1};
        run_frame(-1);
        // Overlapping windows; overflow from the last frame must clear.
        cfg[0] = '{1'b1, 10, 19, 5, 9, 0};
        cfg[1] = '{1'b1, 12, 30, 6, 8, 0};
        run_frame(-1);
        // Inverted bounds: no writes, no frame_done.
        cfg[0] = '{1'b1, 20, 10, 2, 8, 0};
        cfg[1] = '{1'b1, 3, 9, 12, 4, 0};
        run_frame(-1);
        // Reset in the middle of a 100-pixel window, then a full clean frame.
        cfg[0] = '{1'b1, 5, 14, 2, 11, 0};
        cfg[1] = '{1'b0, 0, 39, 0, 23, 0};
        run_frame(8);
        run_frame(-1);

        for (int f = 0; f < 12; f++) begin
            random_cfg();
            run_frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LINES - 1)) : -1);
        end

        repeat (5) @(posedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
